// File: rtl/prog_loader.sv
// Program loader: accepts a LEN/payload/checksum byte stream and writes the payload
// into CPU memory. The CPU is released from reset only after the checksum verifies.
module prog_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wr,
  output logic                  cpu_rst,
  input  logic                  halt,
  output logic                  done,
  output logic                  error,
  output logic                  halted
);

  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [31:0] LP_DEPTH = MEM_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         w_idx_inc;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] w_sum_add;
  logic                  w_xfer;
  logic                  w_len_ok;

  logic                  r_rx_ready;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_wr;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_error;
  logic                  r_halted;

  assign w_xfer    = rx_valid && r_rx_ready;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_sum_add = r_sum + rx_data;
  assign w_len_ok  = (rx_data != '0) && (32'(rx_data) <= LP_DEPTH);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LEN;
      S_LEN:   if (w_xfer) w_next = w_len_ok ? S_LOAD : S_ERR;
      S_LOAD:  if (w_xfer && (w_idx_inc == r_len)) w_next = S_CSUM;
      S_CSUM:  if (w_xfer) w_next = (w_sum_add == '0) ? S_RUN : S_ERR;
      S_RUN:   if (start) w_next = S_LEN;
      S_ERR:   if (start) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state;
  // this also drops halted on the same edge that leaves RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_rx_ready <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next == S_LEN) || (w_next == S_LOAD) || (w_next == S_CSUM);
      r_cpu_rst  <= (w_next == S_RUN);
      r_done     <= (w_next == S_RUN);
      r_error    <= (w_next == S_ERR);
      r_halted   <= halt && (w_next == S_RUN);
      r_mem_wr   <= 1'b0;
      if ((r_state == S_LEN) && w_xfer) begin
        r_len <= rx_data[CW-1:0];
        r_idx <= '0;
        r_sum <= '0;
      end
      if ((r_state == S_LOAD) && w_xfer) begin
        r_mem_wr   <= 1'b1;
        r_mem_addr <= r_idx[ADDR_WIDTH-1:0];
        r_mem_data <= rx_data;
        r_idx      <= w_idx_inc;
        r_sum      <= w_sum_add;
      end
    end
  end

  assign rx_ready = r_rx_ready;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_wr   = r_mem_wr;
  assign cpu_rst  = r_cpu_rst;
  assign done     = r_done;
  assign error    = r_error;
  assign halted   = r_halted;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frame-level reference model predicts memory
// writes and final status; a negedge monitor checks every mem_wr pulse.
module tb_prog_loader;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr;
  logic          cpu_rst;
  logic          halt;
  logic          done;
  logic          error;
  logic          halted;

  prog_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_wr  (mem_wr),
    .cpu_rst (cpu_rst),
    .halt    (halt),
    .done    (done),
    .error   (error),
    .halted  (halted)
  );

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  bit         gaps_en;
  int         n_checks;
  int         n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (rst && mem_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", 32'(mem_data), 32'(e.data));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_mem_wr"},   32'(mem_wr),   0);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),  0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_error"},    32'(error),    0);
    chk({tag, "_halted"},   32'(halted),   0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    if (gaps_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      if (gaps_en && ($urandom_range(0, 1) == 0)) rx_valid = ~rx_valid;
      n++;
    end
    rx_valid = 1'b1;
    if (!rx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_ready_timeout: rx_ready %0b, required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_frame(input int unsigned n, input bit bad);
    int unsigned s;
    logic [7:0]  b;
    frame.delete();
    frame.push_back(8'(n));
    s = 0;
    for (int unsigned i = 0; i < n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      s = (s + b) % 256;
    end
    s = (256 - s) % 256;
    if (bad) s = (s + $urandom_range(1, 255)) % 256;
    frame.push_back(8'(s));
  endtask

  // Reference model at frame level: decides writes and final outcome from the byte list.
  task automatic run_frame();
    int unsigned n;
    int unsigned s;
    bit          ok;
    pulse_start();
    n = frame[0];
    send_byte(frame[0]);
    if (n == 0 || n > DEPTH) begin
      ok = 1'b0;
    end else begin
      s = 0;
      for (int unsigned i = 0; i < n; i++) begin
        wr_t e;
        e.addr = i;
        e.data = frame[i+1];
        exp_q.push_back(e);
        s = s + frame[i+1];
        send_byte(frame[i+1]);
      end
      chk("cpu_rst_before_csum", 32'(cpu_rst), 0);
      ok = ((s + frame[n+1]) % 256) == 0;
      send_byte(frame[n+1]);
    end
    chk("frame_cpu_rst",  32'(cpu_rst),  32'(ok));
    chk("frame_done",     32'(done),     32'(ok));
    chk("frame_error",    32'(error),    32'(!ok));
    chk("frame_rx_ready", 32'(rx_ready), 0);
    chk("frame_writes_drained", exp_q.size(), 0);
  endtask

  // Bytes offered outside a load must be ignored.
  task automatic present_junk(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
      chk("junk_rx_ready", 32'(rx_ready), 0);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    gaps_en  = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    halt     = 1'b0;
    #3 rst = 1'b0;
    #20 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    present_junk(3);
    chk("idle_done", 32'(done), 0);

    // Nominal load
    frame = '{8'h03, 8'h0A, 8'h14, 8'h1E, 8'hC4};
    run_frame();
    present_junk(3);
    chk("run_still_done", 32'(done), 1);

    // Halt then reload
    halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("halted_in_run", 32'(halted), 1);
    pulse_start();
    chk("reload_cpu_rst", 32'(cpu_rst), 0);
    chk("reload_halted",  32'(halted),  0);
    chk("reload_done",    32'(done),    0);
    chk("reload_in_len",  32'(rx_ready), 1);

    // Bad checksum (start inside LEN is ignored)
    frame = '{8'h02, 8'h11, 8'h22, 8'h00};
    run_frame();
    @(negedge clk);
    chk("halted_in_err", 32'(halted), 0);
    halt = 1'b0;
    present_junk(3);
    chk("err_held", 32'(error), 1);
    build_frame(5, 1'b0);
    run_frame();

    // Length bounds
    frame = '{8'h00};
    run_frame();
    frame = '{8'h21};
    run_frame();
    build_frame(32, 1'b0);
    run_frame();

    // Random frames with handshake stalls
    gaps_en = 1'b1;
    build_frame(5, 1'b0);
    run_frame();
    for (int unsigned f = 0; f < 6; f++) begin
      build_frame($urandom_range(1, DEPTH), ($urandom_range(0, 3) == 0));
      run_frame();
    end
    gaps_en = 1'b0;

    // Async reset mid-load after 2 of 4 payload bytes
    pulse_start();
    send_byte(8'h04);
    for (int unsigned i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = i;
      e.data = 8'hA0 + 8'(i) + 8'h5;
      exp_q.push_back(e);
      send_byte(e.data);
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("post_rst_cpu_rst", 32'(cpu_rst), 0);
    chk("post_rst_rx_ready", 32'(rx_ready), 0);
    chk("post_rst_writes_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
